// File: rtl/sal_param_sched.sv
// sal_param_sched: per-bank command scheduler with ACT/ACT and CAS/CAS spacing.
// Optional refresh engine (PREA + REF sequence) built when SAL_SCHED_REFRESH_EN is defined.
module sal_param_sched #(
  parameter int BK_CNT    = 8,
  parameter int ROW_W     = 14,
  parameter int T_RRD     = 2,
  parameter int T_CCD     = 2,
  parameter int CAS_FIRST = 1,
  parameter int T_REFI    = 780,
  parameter int T_RP      = 3,
  parameter int T_RFC     = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BK_CNT-1:0]         bk_req_valid,
  input  logic [2*BK_CNT-1:0]       bk_req_cmd,
  input  logic [ROW_W*BK_CNT-1:0]   bk_req_addr,
  output logic [BK_CNT-1:0]         bk_req_ready,
  output logic                      cmd_valid,
  output logic [2:0]                cmd_type,
  output logic [$clog2(BK_CNT)-1:0] cmd_ba,
  output logic [ROW_W-1:0]          cmd_addr,
  output logic                      ref_done
);

  localparam int BA_W  = $clog2(BK_CNT);
  localparam int RRD_W = (T_RRD > 1) ? $clog2(T_RRD) : 1;
  localparam int CCD_W = (T_CCD > 1) ? $clog2(T_CCD) : 1;

  localparam logic [1:0] RQ_ACT = 2'd0;
  localparam logic [1:0] RQ_RD  = 2'd1;
  localparam logic [1:0] RQ_WR  = 2'd2;
  localparam logic [1:0] RQ_PRE = 2'd3;

  localparam logic [2:0] CT_NOP  = 3'd0;
  localparam logic [2:0] CT_PREA = 3'd5;
  localparam logic [2:0] CT_REF  = 3'd6;

  if (BK_CNT < 2 || BK_CNT > 16 || (BK_CNT & (BK_CNT - 1)) != 0 ||
      ROW_W < 1 || T_RRD < 1 || T_CCD < 1 ||
      T_REFI < 2 || T_RP < 1 || T_RFC < 1) begin : g_cfg_chk
    $error("sal_param_sched: unsupported parameter set");
  end

  logic [1:0]       req_cmd  [BK_CNT];
  logic [ROW_W-1:0] req_addr [BK_CNT];

  logic [BK_CNT-1:0] elig;
  logic [BK_CNT-1:0] cas_elig;
  logic [BK_CNT-1:0] cand;
  logic              pick_hit;
  logic [BA_W-1:0]   pick_idx;
  logic [BA_W-1:0]   last_grant;
  logic              xfer;
  logic [1:0]        g_cmd;
  logic [ROW_W-1:0]  g_addr;
  logic              g_is_cas;

  logic [RRD_W-1:0]  rrd_cnt;
  logic [CCD_W-1:0]  ccd_cnt;

  logic              gate_en;
  logic              ins_prea;
  logic              ins_ref;

  for (genvar gi = 0; gi < BK_CNT; gi++) begin : g_unpack
    assign req_cmd[gi]  = bk_req_cmd[2*gi +: 2];
    assign req_addr[gi] = bk_req_addr[ROW_W*gi +: ROW_W];
  end

  // per-bank eligibility: valid and not held off by its spacing counter
  always_comb begin
    elig     = '0;
    cas_elig = '0;
    for (int i = 0; i < BK_CNT; i++) begin
      case (req_cmd[i])
        RQ_ACT: elig[i] = bk_req_valid[i] && (rrd_cnt == '0);
        RQ_RD,
        RQ_WR: begin
          elig[i]     = bk_req_valid[i] && (ccd_cnt == '0);
          cas_elig[i] = elig[i];
        end
        default: elig[i] = bk_req_valid[i];
      endcase
    end
  end

  // class filter: column commands outrank row commands when enabled
  always_comb begin
    cand = elig;
    if (CAS_FIRST != 0 && |cas_elig) cand = cas_elig;
  end

  // round-robin search starting one past the last granted bank
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= BK_CNT; k++) begin
      if (!pick_hit && cand[last_grant + BA_W'(k)]) begin
        pick_hit = 1'b1;
        pick_idx = last_grant + BA_W'(k);
      end
    end
  end

  assign xfer         = pick_hit && gate_en && !rst;
  assign bk_req_ready = xfer ? (BK_CNT'(1) << pick_idx) : '0;
  assign g_cmd        = req_cmd[pick_idx];
  assign g_addr       = req_addr[pick_idx];
  assign g_is_cas     = (g_cmd == RQ_RD) || (g_cmd == RQ_WR);

  // round-robin pointer moves only on an actual transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= BA_W'(BK_CNT - 1);
    end else if (xfer) begin
      last_grant <= pick_idx;
    end
  end

  // ACT-to-ACT and CAS-to-CAS spacing counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
    end else begin
      if (xfer && g_cmd == RQ_ACT) begin
        rrd_cnt <= RRD_W'(T_RRD - 1);
      end else if (rrd_cnt != '0) begin
        rrd_cnt <= rrd_cnt - 1'b1;
      end
      if (xfer && g_is_cas) begin
        ccd_cnt <= CCD_W'(T_CCD - 1);
      end else if (ccd_cnt != '0) begin
        ccd_cnt <= ccd_cnt - 1'b1;
      end
    end
  end

  // registered command bus: granted command, refresh command or NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_type  <= CT_NOP;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
    end else if (xfer) begin
      cmd_valid <= 1'b1;
      cmd_type  <= {1'b0, g_cmd} + 3'd1;
      cmd_ba    <= pick_idx;
      cmd_addr  <= (g_cmd == RQ_PRE) ? '0 : g_addr;
    end else if (ins_prea) begin
      cmd_valid <= 1'b1;
      cmd_type  <= CT_PREA;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
    end else if (ins_ref) begin
      cmd_valid <= 1'b1;
      cmd_type  <= CT_REF;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_type  <= CT_NOP;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
    end
  end

`ifdef SAL_SCHED_REFRESH_EN
  localparam int REFI_W = $clog2(T_REFI + 1);
  localparam int WT_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int WAIT_W = $clog2(WT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREA,
    S_WAIT_RP,
    S_REF,
    S_WAIT_RFC
  } ref_st_t;

  ref_st_t           st_q;
  ref_st_t           st_d;
  logic [REFI_W-1:0] refi_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ref_pend;

  // free-running refresh interval timer; one pending flag, never stacked
  always_ff @(posedge clk) begin
    if (rst) begin
      refi_cnt <= REFI_W'(T_REFI - 1);
      ref_pend <= 1'b0;
    end else begin
      if (refi_cnt == '0) begin
        refi_cnt <= REFI_W'(T_REFI - 1);
      end else begin
        refi_cnt <= refi_cnt - 1'b1;
      end
      if (st_q == S_REF) begin
        ref_pend <= 1'b0;
      end else if (refi_cnt == '0) begin
        ref_pend <= 1'b1;
      end
    end
  end

  // refresh state register, wait timer and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_IDLE;
      wait_cnt <= '0;
      ref_done <= 1'b0;
    end else begin
      st_q     <= st_d;
      ref_done <= (st_q == S_REF);
      if (st_q == S_PREA) begin
        wait_cnt <= WAIT_W'(T_RP - 1);
      end else if (st_q == S_REF) begin
        wait_cnt <= WAIT_W'(T_RFC - 1);
      end else if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // refresh next state, grant gating and command insertion
  always_comb begin
    st_d     = st_q;
    gate_en  = 1'b0;
    ins_prea = 1'b0;
    ins_ref  = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (ref_pend) st_d = S_PREA;
        else gate_en = 1'b1;
      end
      S_PREA: begin
        ins_prea = 1'b1;
        st_d     = S_WAIT_RP;
      end
      S_WAIT_RP: begin
        if (wait_cnt == '0) st_d = S_REF;
      end
      S_REF: begin
        ins_ref = 1'b1;
        st_d    = S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        if (wait_cnt == '0) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end
`else
  assign gate_en  = 1'b1;
  assign ins_prea = 1'b0;
  assign ins_ref  = 1'b0;
  assign ref_done = 1'b0;
`endif

endmodule

// File: tb/tb_sal_param_sched.sv
// tb_sal_param_sched: directed table, reset-in-refresh sequence and
// randomized traffic against a timestamp-based reference model.
module tb_sal_param_sched;

  localparam int NB     = 8;
  localparam int RW     = 14;
  localparam int P_RRD  = 4;
  localparam int P_CCD  = 2;
  localparam int P_REFI = 20;
  localparam int P_RP   = 3;
  localparam int P_RFC  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     valid;
  logic [2*NB-1:0]   cmd;
  logic [RW*NB-1:0]  addr;
  logic [NB-1:0]     ready;
  logic              cmd_valid;
  logic [2:0]        cmd_type;
  logic [2:0]        cmd_ba;
  logic [RW-1:0]     cmd_addr;
  logic              ref_done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [NB-1:0]   v;
    logic [2*NB-1:0] c;
    int              gnt;
  } vec_t;

  vec_t tbl [16];

  int m_last, m_act, m_cas, m_cyc, m_phase;
  bit m_pend;
  int e_v, e_t, e_ba, e_addr, e_rd;

  always #5 clk = ~clk;

  sal_param_sched #(
    .BK_CNT(NB), .ROW_W(RW), .T_RRD(P_RRD), .T_CCD(P_CCD),
    .CAS_FIRST(1), .T_REFI(P_REFI), .T_RP(P_RP), .T_RFC(P_RFC)
  ) dut (
    .clk(clk), .rst(rst),
    .bk_req_valid(valid), .bk_req_cmd(cmd), .bk_req_addr(addr),
    .bk_req_ready(ready),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
    .ref_done(ref_done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = '1;
    cmd   = 16'h5555;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd_type", int'(cmd_type), 0);
    chk("rst_cmd_ba", int'(cmd_ba), 0);
    chk("rst_cmd_addr", int'(cmd_addr), 0);
    chk("rst_ref_done", int'(ref_done), 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = '0;
  endtask

  task automatic model_reset();
    m_last  = NB - 1;
    m_act   = -1000;
    m_cas   = -1000;
    m_cyc   = 0;
    m_phase = -1;
    m_pend  = 1'b0;
    e_v = 0; e_t = 0; e_ba = 0; e_addr = 0; e_rd = 0;
  endtask

  task automatic check_prev(input vec_t p, input int i);
    logic [1:0] c;
    if (p.gnt < 0) begin
      chk($sformatf("tbl%0d_cmd_valid", i), int'(cmd_valid), 0);
      chk($sformatf("tbl%0d_cmd_type", i), int'(cmd_type), 0);
    end else begin
      c = p.c[2*p.gnt +: 2];
      chk($sformatf("tbl%0d_cmd_valid", i), int'(cmd_valid), 1);
      chk($sformatf("tbl%0d_cmd_type", i), int'(cmd_type), int'(c) + 1);
      chk($sformatf("tbl%0d_cmd_ba", i), int'(cmd_ba), p.gnt);
      chk($sformatf("tbl%0d_cmd_addr", i), int'(cmd_addr),
          (c == 2'd3) ? 0 : (p.gnt * 100 + 7));
    end
  endtask

  task automatic run_random(input int n);
    int best;
    bit gate;
    bit ref_now;
    logic [1:0] c;
    for (int t = 0; t < n; t++) begin
      valid = NB'($urandom);
      cmd   = (2*NB)'($urandom);
      for (int b = 0; b < NB; b++) addr[RW*b +: RW] = RW'($urandom);
      @(negedge clk);
      chk("rnd_cmd_valid", int'(cmd_valid), e_v);
      chk("rnd_cmd_type", int'(cmd_type), e_t);
      if (e_v != 0) begin
        chk("rnd_cmd_ba", int'(cmd_ba), e_ba);
        chk("rnd_cmd_addr", int'(cmd_addr), e_addr);
      end
      chk("rnd_ref_done", int'(ref_done), e_rd);
      gate = 1'b1;
`ifdef SAL_SCHED_REFRESH_EN
      gate = (m_phase < 0) && !m_pend;
`endif
      best = -1;
      if (gate) begin
        for (int pass = 0; pass < 2 && best < 0; pass++) begin
          for (int k = 1; k <= NB && best < 0; k++) begin
            int b;
            bit ok;
            bit is_cas;
            b = (m_last + k) % NB;
            c = cmd[2*b +: 2];
            is_cas = (c == 2'd1) || (c == 2'd2);
            if (c == 2'd0) ok = (m_cyc - m_act) >= P_RRD;
            else if (c == 2'd3) ok = 1'b1;
            else ok = (m_cyc - m_cas) >= P_CCD;
            if (valid[b] && ok && (pass == 1 || is_cas)) best = b;
          end
        end
      end
      chk("rnd_ready", int'(ready), (best < 0) ? 0 : (1 << best));
      e_v = 0; e_t = 0; e_ba = 0; e_addr = 0; e_rd = 0;
      if (best >= 0) begin
        c = cmd[2*best +: 2];
        e_v    = 1;
        e_t    = int'(c) + 1;
        e_ba   = best;
        e_addr = (c == 2'd3) ? 0 : int'(addr[RW*best +: RW]);
        m_last = best;
        if (c == 2'd0) m_act = m_cyc;
        if (c == 2'd1 || c == 2'd2) m_cas = m_cyc;
      end
`ifdef SAL_SCHED_REFRESH_EN
      if (m_phase == 0) begin
        e_v = 1; e_t = 5;
      end
      ref_now = (m_phase == P_RP + 1);
      if (ref_now) begin
        e_v = 1; e_t = 6; e_rd = 1;
      end
      if (m_phase >= 0) begin
        m_phase++;
        if (m_phase == 2 + P_RP + P_RFC) m_phase = -1;
      end else if (m_pend) begin
        m_phase = 0;
      end
      if (ref_now) m_pend = 1'b0;
      else if ((m_cyc + 1) % P_REFI == 0) m_pend = 1'b1;
`else
      ref_now = 1'b0;
`endif
      m_cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    tbl[0]  = '{8'h09, 16'h0040, 3};
    tbl[1]  = '{8'h09, 16'h0040, 0};
    tbl[2]  = '{8'h24, 16'h0410, 2};
    tbl[3]  = '{8'h24, 16'h0410, -1};
    tbl[4]  = '{8'h24, 16'h0410, 5};
    tbl[5]  = '{8'h24, 16'h0410, -1};
    tbl[6]  = '{8'h24, 16'h0410, 2};
    tbl[7]  = '{8'h12, 16'h0300, 4};
    tbl[8]  = '{8'h12, 16'h0300, 1};
    tbl[9]  = '{8'h12, 16'h0000, -1};
    tbl[10] = '{8'h00, 16'h0000, -1};
    tbl[11] = '{8'h10, 16'h0000, -1};
    tbl[12] = '{8'h10, 16'h0000, 4};
    tbl[13] = '{8'hC1, 16'hE000, 6};
    tbl[14] = '{8'hC1, 16'hE000, 7};
    tbl[15] = '{8'h00, 16'h0000, -1};

    for (int b = 0; b < NB; b++) addr[RW*b +: RW] = RW'(b * 100 + 7);
    cmd   = '0;
    valid = '0;
    rst   = 1'b1;

    do_reset();
    for (int i = 0; i < 16; i++) begin
      valid = tbl[i].v;
      cmd   = tbl[i].c;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), int'(ready),
          (tbl[i].gnt < 0) ? 0 : (1 << tbl[i].gnt));
      if (i > 0) check_prev(tbl[i-1], i - 1);
      @(posedge clk);
      #1;
    end
    valid = '0;
    @(negedge clk);
    check_prev(tbl[15], 15);
    @(posedge clk);
    #1;

`ifdef SAL_SCHED_REFRESH_EN
    do_reset();
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (cmd_type == 3'd5) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("prea_seen", int'(found), 1);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    valid = '1;
    cmd   = 16'h5555;
    @(negedge clk);
    chk("rst_rp_ready", int'(ready), 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = '0;
    @(negedge clk);
    chk("rst_rp_cmd_valid", int'(cmd_valid), 0);
    chk("rst_rp_ready_after", int'(ready), 0);
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_rp_no_ref_type", int'(cmd_type), 0);
      chk("rst_rp_no_ref_done", int'(ref_done), 0);
    end
    @(posedge clk);
    #1;
    valid = 8'h08;
    cmd   = 16'h0040;
    @(negedge clk);
    chk("rst_rp_idle_grant", int'(ready), 8);
    @(posedge clk);
    #1;
`endif

    do_reset();
    model_reset();
    run_random(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
